// File: rtl/riscv_decode_stage.sv
// riscv_decode_stage
//   Registered RV32I decode stage between fetch and execute. An {pc, instr}
//   pair accepted on the input handshake is decoded combinationally and
//   registered, and it appears on the outputs one cycle later. With SKID=1 a
//   second register absorbs one entry under backpressure, so in_ready comes
//   straight from a flop. A synchronous flush drops every held entry and any
//   entry presented in the same cycle.
// Ports
//   clk, resetn        clock, asynchronous active-low reset
//   flush              drop held entries and the entry presented this cycle
//   in_valid/in_ready  upstream handshake carrying in_instr / in_pc
//   out_valid/out_ready downstream handshake
//   out_pc             pc of the decoded entry
//   out_flags          one-hot {SYSTEM,Store,Load,LUI,AUIPC,JAL,JALR,Branch,ALUimm,ALUreg}
//   out_rs1/rs2/rd     raw register-id slices of the instruction
//   out_funct3/funct7  raw funct slices of the instruction
//   out_imm            sign-extended immediate selected by instruction type
//   out_illegal        opcode not recognised
module riscv_decode_stage #(
    parameter int PC_WIDTH = 32,
    parameter bit SKID     = 1'b1
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [31:0]         in_instr,
    input  logic [PC_WIDTH-1:0] in_pc,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [PC_WIDTH-1:0] out_pc,
    output logic [9:0]          out_flags,
    output logic [4:0]          out_rs1,
    output logic [4:0]          out_rs2,
    output logic [4:0]          out_rd,
    output logic [2:0]          out_funct3,
    output logic [6:0]          out_funct7,
    output logic [31:0]         out_imm,
    output logic                out_illegal
);

    // Decoded entry. Opcode bits are not kept: flags/illegal replace them.
    typedef struct packed {
        logic [PC_WIDTH-1:0] pc;
        logic [31:7]         instr;
        logic [9:0]          flags;
        logic [31:0]         imm;
        logic                illegal;
    } entry_t;

    function automatic entry_t decode(input logic [PC_WIDTH-1:0] pc, input logic [31:0] i);
        entry_t e;
        e.pc      = pc;
        e.instr   = i[31:7];
        e.flags   = '0;
        e.imm     = '0;
        e.illegal = 1'b0;
        case (i[6:0])
            7'b0110011: e.flags[0] = 1'b1;                                   // ALUreg, no imm
            7'b0010011: begin e.flags[1] = 1'b1; e.imm = {{21{i[31]}}, i[30:20]}; end
            7'b1100011: begin e.flags[2] = 1'b1; e.imm = {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0}; end
            7'b1100111: begin e.flags[3] = 1'b1; e.imm = {{21{i[31]}}, i[30:20]}; end
            7'b1101111: begin e.flags[4] = 1'b1; e.imm = {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0}; end
            7'b0010111: begin e.flags[5] = 1'b1; e.imm = {i[31:12], 12'b0}; end
            7'b0110111: begin e.flags[6] = 1'b1; e.imm = {i[31:12], 12'b0}; end
            7'b0000011: begin e.flags[7] = 1'b1; e.imm = {{21{i[31]}}, i[30:20]}; end
            7'b0100011: begin e.flags[8] = 1'b1; e.imm = {{21{i[31]}}, i[30:25], i[11:7]}; end
            7'b1110011: begin e.flags[9] = 1'b1; e.imm = {{21{i[31]}}, i[30:20]}; end
            default:    e.illegal = 1'b1;
        endcase
        return e;
    endfunction

    entry_t out_q, out_d;
    entry_t skid_q, skid_d;
    logic   out_valid_q, out_valid_d;
    logic   skid_full_q, skid_full_d;
    entry_t in_entry;
    logic   accept;
    logic   drain;

    always_comb begin
        in_entry = decode(in_pc, in_instr);
        if (SKID) begin
            in_ready = !skid_full_q;
        end else begin
            in_ready = !out_valid_q || out_ready;
        end
        accept = in_valid && in_ready;
        drain  = out_valid_q && out_ready;
    end

    always_comb begin
        out_d       = out_q;
        out_valid_d = out_valid_q;
        skid_d      = skid_q;
        skid_full_d = skid_full_q;
        if (flush) begin
            // Flush wins over everything; a same-cycle accept is silently dropped.
            out_valid_d = 1'b0;
            skid_full_d = 1'b0;
        end else if (SKID) begin
            if (!out_valid_q || drain) begin
                // Output slot frees up: the older skid entry goes first. in_ready
                // is low while the skid is full, so no accept can collide here.
                if (skid_full_q) begin
                    out_d       = skid_q;
                    out_valid_d = 1'b1;
                    skid_full_d = 1'b0;
                end else if (accept) begin
                    out_d       = in_entry;
                    out_valid_d = 1'b1;
                end else begin
                    out_valid_d = 1'b0;
                end
            end else if (accept) begin
                skid_d      = in_entry;
                skid_full_d = 1'b1;
            end
        end else begin
            if (accept) begin
                out_d       = in_entry;
                out_valid_d = 1'b1;
            end else if (drain) begin
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            out_q       <= '0;
            skid_q      <= '0;
            out_valid_q <= 1'b0;
            skid_full_q <= 1'b0;
        end else begin
            out_q       <= out_d;
            skid_q      <= skid_d;
            out_valid_q <= out_valid_d;
            skid_full_q <= skid_full_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_pc      = out_q.pc;
    assign out_flags   = out_q.flags;
    assign out_rs1     = out_q.instr[19:15];
    assign out_rs2     = out_q.instr[24:20];
    assign out_rd      = out_q.instr[11:7];
    assign out_funct3  = out_q.instr[14:12];
    assign out_funct7  = out_q.instr[31:25];
    assign out_imm     = out_q.imm;
    assign out_illegal = out_q.illegal;

endmodule
